// File: rtl/aes_rkey_sched_if.sv
// aes_rkey_sched_if: start/key request and round-key handshake between the key register, the scheduler and the round engine.
interface aes_rkey_sched_if;
    logic         i_Start;
    logic [127:0] i_Key;
    logic         i_fDec;
    logic         i_Next;
    logic [127:0] o_RKey;
    logic [3:0]   o_Rnd;
    logic         o_Valid;
    logic         o_Busy;
    logic         o_Done;
    modport master (output i_Start, i_Key, i_fDec, i_Next, input o_RKey, o_Rnd, o_Valid, o_Busy, o_Done);
    modport slave  (input i_Start, i_Key, i_fDec, i_Next, output o_RKey, o_Rnd, o_Valid, o_Busy, o_Done);
endinterface

// File: rtl/aes_rkey_sched.sv
// aes_rkey_sched: AES-128 round-key scheduler emitting keys 0..10 forward or 10..0 reverse, one per handshake.
module aes_rkey_sched (
    input logic             i_Clk,
    input logic             i_Rst,
    aes_rkey_sched_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, PREP = 2'd1, EMIT = 2'd2, DONE = 2'd3;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // GF(2^8) inverse as x^254 (zero maps to zero), followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] p, r;
        p = b;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd0: return 8'h01;
            4'd1: return 8'h02;
            4'd2: return 8'h04;
            4'd3: return 8'h08;
            4'd4: return 8'h10;
            4'd5: return 8'h20;
            4'd6: return 8'h40;
            4'd7: return 8'h80;
            4'd8: return 8'h1b;
            default: return 8'h36;
        endcase
    endfunction

    logic [1:0]   state_q, state_d;
    logic [127:0] key_q, key_d;
    logic         dec_q, dec_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         valid_q, busy_q, done_q;

    logic [31:0]  w0, w1, w2, w3, n3, sub_in, t, f0, f1, f2;
    logic [3:0]   idx;
    logic         inv, last;
    logic [127:0] step_key;

    assign {w0, w1, w2, w3} = key_q;
    assign inv = dec_q && state_q == EMIT;
    assign n3 = w3 ^ w2;
    // one S-box row serves both directions: the inverse step needs the recovered w3
    assign sub_in = inv ? n3 : w3;
    assign idx = inv ? cnt_q - 4'd1 : cnt_q;
    assign t = subword({sub_in[23:0], sub_in[31:24]}) ^ {rcon(idx), 24'h0};
    assign f0 = w0 ^ t;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign step_key = inv ? {w0 ^ t, w1 ^ w0, w2 ^ w1, n3} : {f0, f1, f2, w3 ^ f2};
    assign last = dec_q ? cnt_q == 4'd0 : cnt_q == 4'd10;

    always_comb begin
        state_d = state_q;
        key_d = key_q;
        dec_d = dec_q;
        cnt_d = cnt_q;
        if (state_q == IDLE || state_q == DONE) begin
            state_d = IDLE;
            if (bus.i_Start) begin
                key_d = bus.i_Key;
                dec_d = bus.i_fDec;
                cnt_d = 4'd0;
                state_d = bus.i_fDec ? PREP : EMIT;
            end
        end else if (state_q == PREP) begin
            key_d = step_key;
            cnt_d = cnt_q + 4'd1;
            state_d = cnt_q == 4'd9 ? EMIT : PREP;
        end else if (bus.i_Next) begin
            state_d = last ? DONE : EMIT;
            key_d = last ? key_q : step_key;
            cnt_d = last ? cnt_q : (dec_q ? cnt_q - 4'd1 : cnt_q + 4'd1);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= IDLE;
            key_q <= '0;
            dec_q <= 1'b0;
            cnt_q <= '0;
            valid_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q <= key_d;
            dec_q <= dec_d;
            cnt_q <= cnt_d;
            valid_q <= state_d == EMIT;
            busy_q <= state_d == PREP || state_d == EMIT;
            done_q <= state_d == DONE;
        end
    end

    assign bus.o_RKey = key_q;
    assign bus.o_Rnd = cnt_q;
    assign bus.o_Valid = valid_q;
    assign bus.o_Busy = busy_q;
    assign bus.o_Done = done_q;
endmodule

// File: doc/aes_rkey_sched.md
# aes_rkey_sched

Sequential AES-128 round-key scheduler that feeds the cipher datapath one 128-bit round key per handshake. For encryption it emits round keys in forward order, 0 through 10. For decryption it first expands the cipher key forward to round 10, then emits keys in reverse order, 10 down to 0, recovering each earlier key with the inverse schedule step. It sits between the key register and the round engine, so round keys never need to be stored.

## Interface
No parameters; AES-128 only.
- i_Clk  in  1  clock; all logic on the rising edge
- i_Rst  in  1  synchronous, active-high reset
- i_Start  in  1  request a new schedule; sampled only in IDLE or DONE
- i_Key  in  128  cipher key, word w0 = [127:96] … w3 = [31:0]; sampled with i_Start
- i_fDec  in  1  0 = forward order, 1 = reverse order; sampled with i_Start
- i_Next  in  1  consumer accepts the current key; effective only when o_Valid = 1
- o_RKey  out  128  current round key
- o_Rnd  out  4  round index of o_RKey (0–10)
- o_Valid  out  1  o_RKey/o_Rnd are valid
- o_Busy  out  1  1 in PREP and EMIT
- o_Done  out  1  one-cycle pulse after the final key is accepted

## Operation
- States: IDLE, PREP, EMIT, DONE.
- **IDLE/DONE + i_Start:**
  - Latch i_Key into the key register and i_fDec into the mode flag.
  - fDec = 0: go to EMIT with round = 0.
  - fDec = 1: go to PREP with step = 0.
- **Forward step at index r (0–9):**
  - t = SubWord(RotWord(w3)) ^ {Rcon[r], 24'h0}.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - RotWord rotates bytes left by one. SubWord applies the forward S-box to each byte.
  - Rcon[0..9] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- **Inverse step at index r:**
  - w3 = w3'^w2'; w2 = w2'^w1'; w1 = w1'^w0'.
  - w0 = w0' ^ SubWord(RotWord(w3)) ^ {Rcon[r], 24'h0}.
  - Only 4 forward S-boxes are used, shared by both steps through a mux on the input word.
- **PREP:**
  - Each cycle, apply the forward step at step index, then step++.
  - After step 9 is applied, go to EMIT with round = 10.
- **EMIT:** o_Valid = 1, o_RKey = key register, o_Rnd = round. On i_Next:
  - Forward mode, round < 10: apply the forward step at index round, then round++.
  - Reverse mode, round > 0: apply the inverse step at index round-1, then round--.
  - Final round accepted (10 forward, 0 reverse): go to DONE.
  - Without i_Next, all outputs hold.
- **DONE:**
  - o_Done = 1 and o_Valid = 0 for exactly one cycle.
  - Next state is IDLE, or a new start if i_Start = 1.
- **Ignored inputs:**
  - i_Start in PREP or EMIT (no restart).
  - i_Next when o_Valid = 0.
  - i_Key and i_fDec except on an accepted start.
- **Reset:**
  - Synchronous reset forces IDLE on the next edge, from any state including mid-PREP or mid-EMIT.
  - Reset values: o_RKey = 0, o_Rnd = 0, o_Valid = 0, o_Busy = 0, o_Done = 0.
  - The key register and mode flag are cleared.
- **Counter width:** round and step are 4-bit and never leave 0–10.

## Timing
- All outputs are registered.
- Forward mode: start sampled at edge T; o_Valid = 1 with o_Rnd = 0 from cycle T+1.
- Reverse mode: PREP occupies cycles T+1 … T+10; o_Valid = 1 with o_Rnd = 10 from cycle T+11.
- i_Next sampled at edge E: the next key is on o_RKey at E+1, with no bubble. Back-to-back i_Next gives one key per cycle.
- Final i_Next at edge E: o_Done = 1 during E+1. A new start sampled at E+1 behaves as a start from IDLE.
- o_Busy = 1 from T+1 until the cycle before o_Done.
- One forward or inverse step, including the S-box path, must complete within one cycle.

## Test plan
- **Forward, FIPS-197 key:** i_Key = 2b7e151628aed2a6abf7158809cf4f3c, i_fDec = 0, i_Next held high.
  - Keys emitted on consecutive cycles, with o_Rnd incrementing by 1 each cycle.
  - Rnd 0 = input key; rnd 1 = a0fafe1788542cb123a339392a6c7605; rnd 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - o_Done pulses one cycle after rnd 10 is accepted.
- **Reverse, same key:** i_fDec = 1.
  - o_Valid first rises 11 cycles after start, with rnd 10 = d014f9a8….
  - Rnd 1 = a0fafe17…; rnd 0 = 2b7e1516…; then o_Done.
- **Stall handling:** random i_Next gaps of 0–5 cycles.
  - o_RKey and o_Rnd stay stable while i_Next = 0.
  - No key is skipped or repeated.
- **Ignored inputs:**
  - i_Start pulsed with a different key during PREP and during EMIT: no effect on the sequence.
  - i_Next pulsed while o_Valid = 0: ignored.
- **Reset mid-operation:** i_Rst asserted at rnd 5 of a forward run and during PREP step 4.
  - Next cycle, all outputs = 0 and state = IDLE.
  - A fresh start then reproduces the full vectors.
- **Back-to-back starts:** i_Start asserted in the o_Done cycle with i_fDec toggled.
  - The new run begins with the correct first key and latency.
- **Randomized:** 1000 random keys in both modes, checked against a reference model.
